// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported synchronous RAM between the CPU
// instruction-fetch port and the load/store port.
// Loads and stores win over fetch because the MEM-stage instruction is older.
// Read data comes back one cycle after the grant, on the port that owned
// that access.
// Optional feature: define ARB_STARVE_GUARD_EN to enable the fetch
// starvation guard. After STARVE_MAX data grants that blocked a pending
// fetch, the guard forces one fetch grant.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_AW     = 6,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   // instruction-fetch port
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_valid,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_stall,
   // load/store port
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_stall,
   // RAM port
   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // Which port the RAM read data belongs to in the current cycle.
   typedef enum logic [1:0] {
      OWN_NONE   = 2'd0,
      OWN_IFETCH = 2'd1,
      OWN_DLOAD  = 2'd2
   } owner_t;

   owner_t            owner;
   owner_t            owner_next;
   logic              d_req;
   logic              force_fetch;
   logic [DATA_W-1:0] i_hold;
   logic [DATA_W-1:0] d_hold;

   // The byte-lane bits and the bits above the RAM size are dropped.
   // This makes out-of-range addresses wrap.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_addr[ADDR_W-1:MEM_AW+2], i_addr[1:0],
                               d_addr[ADDR_W-1:MEM_AW+2], d_addr[1:0]};

   assign d_req = d_read | d_write;

`ifdef ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt;

   // This counter tracks data grants that blocked a waiting fetch.
   // It saturates at STARVE_MAX, and any fetch grant clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (i_gnt) begin
         starve_cnt <= '0;
      end else if (d_gnt && i_req && (starve_cnt != CNT_MAX)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   assign force_fetch = i_req && (starve_cnt >= CNT_MAX);
`else
   assign force_fetch = 1'b0;
`endif

   // Same-cycle grant: data first unless the guard forces fetch. Reset blocks all grants.
   always_comb begin
      d_gnt = 1'b0;
      i_gnt = 1'b0;
      if (!rst) begin
         if (d_req && !force_fetch) begin
            d_gnt = 1'b1;
         end else if (i_req) begin
            i_gnt = 1'b1;
         end
      end
   end

   assign i_stall = i_req & ~i_gnt;
   assign d_stall = d_req & ~d_gnt;

   // Drive the RAM from the granted port.
   // When both d_read and d_write are high, the write wins.
   always_comb begin
      mem_en    = i_gnt | d_gnt;
      mem_we    = d_gnt & d_write;
      mem_addr  = d_gnt ? d_addr[MEM_AW+1:2] : i_addr[MEM_AW+1:2];
      mem_wdata = d_wdata;
   end

   // Owner register: records which port owns the RAM data due next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner <= OWN_NONE;
      end else begin
         owner <= owner_next;
      end
   end

   // Next owner comes from this cycle's grant. A store returns nothing, so it gives NONE.
   always_comb begin
      owner_next = OWN_NONE;
      if (d_gnt && !d_write) begin
         owner_next = OWN_DLOAD;
      end else if (i_gnt) begin
         owner_next = OWN_IFETCH;
      end
   end

   // Capture returned words so each port's data holds while its valid is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_hold <= '0;
         d_hold <= '0;
      end else begin
         if (owner == OWN_IFETCH) begin
            i_hold <= mem_rdata;
         end
         if (owner == OWN_DLOAD) begin
            d_hold <= mem_rdata;
         end
      end
   end

   // Response outputs: valids decode the owner register.
   // The owning port sees live RAM data, and the other port shows its held word.
   always_comb begin
      i_valid = (owner == OWN_IFETCH);
      d_valid = (owner == OWN_DLOAD);
      i_rdata = i_valid ? mem_rdata : i_hold;
      d_rdata = d_valid ? mem_rdata : d_hold;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. It contains a behavioural RAM and a reference
// model that predicts grants and responses every cycle.
// It also runs directed scenarios with literal expectations and a
// randomized phase.
module tb_mem_arbiter;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int MEM_AW     = 6;
   localparam int STARVE_MAX = 4;
   localparam int WORDS      = 64;
`ifdef ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_valid;
   logic [DATA_W-1:0] i_rdata;
   logic              i_stall;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_valid;
   logic [DATA_W-1:0] d_rdata;
   logic              d_stall;
   logic              mem_en;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   int n_chk;
   int n_fail;

   mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid),
      .i_rdata(i_rdata), .i_stall(i_stall),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-ported synchronous RAM: writes at the edge, read data one cycle later.
   logic [DATA_W-1:0] ram [WORDS];
   logic [DATA_W-1:0] ram_q;
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        ram_q <= ram[mem_addr];
      end
   end
   assign mem_rdata = ram_q;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model state: shadow memory, next-cycle responses, starvation count.
   logic [DATA_W-1:0] mmem [WORDS];
   logic              m_iv, m_dv;
   logic [DATA_W-1:0] m_ir, m_dr;
   int                m_cnt;

   initial begin
      m_iv = 1'b0; m_dv = 1'b0; m_ir = '0; m_dr = '0; m_cnt = 0;
   end

   // Check the DUT against the model on every falling edge, then advance the model.
   always @(negedge clk) begin
      logic dreq, frc, e_dg, e_ig;
      int   ia, da;
      if (rst) begin
         m_iv = 1'b0; m_dv = 1'b0; m_ir = '0; m_dr = '0; m_cnt = 0;
      end
      dreq = d_read | d_write;
      frc  = GUARD && i_req && (m_cnt >= STARVE_MAX);
      e_dg = !rst && dreq && !frc;
      e_ig = !rst && i_req && !e_dg;
      ia   = int'((i_addr >> 2) % WORDS);
      da   = int'((d_addr >> 2) % WORDS);
      chk("m_i_gnt",   i_gnt,   e_ig);
      chk("m_d_gnt",   d_gnt,   e_dg);
      chk("m_i_stall", i_stall, i_req && !e_ig);
      chk("m_d_stall", d_stall, dreq && !e_dg);
      chk("m_mem_en",  mem_en,  e_ig || e_dg);
      chk("m_mem_we",  mem_we,  e_dg && d_write);
      if (e_ig || e_dg) chk("m_mem_addr", 32'(mem_addr), e_dg ? da : ia);
      if (e_dg && d_write) chk("m_mem_wdata", mem_wdata, d_wdata);
      chk("m_i_valid", i_valid, m_iv);
      chk("m_d_valid", d_valid, m_dv);
      chk("m_i_rdata", i_rdata, m_ir);
      chk("m_d_rdata", d_rdata, m_dr);
      m_iv = e_ig;
      if (e_ig) m_ir = mmem[ia];
      m_dv = e_dg && !d_write;
      if (m_dv) m_dr = mmem[da];
      if (e_dg && d_write) mmem[da] = d_wdata;
      if (e_ig) m_cnt = 0;
      else if (e_dg && i_req && m_cnt < STARVE_MAX) m_cnt++;
   end

   // Apply one cycle of inputs just after the rising edge, then return after the falling edge.
   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic dw, input logic [31:0] da, input logic [31:0] dd);
      @(posedge clk); #1;
      i_req = ir; i_addr = ia; d_read = dr; d_write = dw; d_addr = da; d_wdata = dd;
      @(negedge clk); #1;
   endtask

   logic [31:0] boot [3];

   initial begin
      boot[0] = 32'h0000_0213; boot[1] = 32'h0002_2283; boot[2] = 32'h0042_0213;
      n_chk = 0; n_fail = 0;
      rst = 1'b1; i_req = 1'b1; i_addr = '0; d_read = 1'b1; d_write = 1'b0;
      d_addr = '0; d_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_i_valid", i_valid, 0);
      chk("rst_d_valid", d_valid, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_i_gnt", i_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      @(posedge clk); #1;
      rst = 1'b0; i_req = 1'b0; d_read = 1'b0;

      // Preload the RAM through the store port.
      for (int w = 0; w < WORDS; w++)
         drive(0, 0, 0, 1, 32'(w * 4), (w < 3) ? boot[w] : $urandom);
      chk("store_no_dvalid", d_valid, 0);

      // Fetch-only stream
      drive(1, 32'h0, 0, 0, 0, 0);
      chk("fetch0_gnt", i_gnt, 1);
      drive(1, 32'h4, 0, 0, 0, 0);
      chk("fetch1_gnt", i_gnt, 1);
      chk("fetch0_data", i_rdata, 32'h0000_0213);
      drive(1, 32'h8, 0, 0, 0, 0);
      chk("fetch2_gnt", i_gnt, 1);
      chk("fetch1_data", i_rdata, 32'h0002_2283);
      drive(0, 0, 0, 0, 0, 0);
      chk("fetch2_valid", i_valid, 1);
      chk("fetch2_data", i_rdata, 32'h0042_0213);
      drive(0, 0, 0, 0, 0, 0);
      chk("fetch_idle_valid", i_valid, 0);
      chk("fetch_hold_data", i_rdata, 32'h0042_0213);

      // Contention: data wins, and fetch retries.
      drive(0, 0, 0, 1, 32'h0, 32'd5);
      drive(1, 32'h0, 1, 0, 32'h0, 0);
      chk("cont_d_gnt", d_gnt, 1);
      chk("cont_i_gnt", i_gnt, 0);
      chk("cont_i_stall", i_stall, 1);
      drive(1, 32'h0, 0, 0, 0, 0);
      chk("cont_retry_gnt", i_gnt, 1);
      chk("cont_d_valid", d_valid, 1);
      chk("cont_d_rdata", d_rdata, 5);
      drive(0, 0, 0, 0, 0, 0);
      chk("cont_i_valid", i_valid, 1);
      chk("cont_i_rdata", i_rdata, 5);

      // Store then load of the same word
      drive(0, 0, 0, 1, 32'h2C, 32'd12);
      chk("st_we", mem_we, 1);
      chk("st_addr", 32'(mem_addr), 11);
      drive(0, 0, 1, 0, 32'h2C, 0);
      chk("st_no_dvalid", d_valid, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("ld_valid", d_valid, 1);
      chk("ld_data", d_rdata, 12);

      // Wrap and byte-offset ignore
      drive(0, 0, 1, 0, 32'h103, 0);
      chk("wrap_addr", 32'(mem_addr), 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("wrap_data", d_rdata, 5);

      // Reset during an in-flight load
      drive(0, 0, 1, 0, 32'h2C, 0);
      @(posedge clk); #1;
      rst = 1'b1; i_req = 1'b1; d_read = 1'b1;
      @(negedge clk); #1;
      chk("rstmid_d_valid", d_valid, 0);
      chk("rstmid_d_rdata", d_rdata, 0);
      chk("rstmid_i_rdata", i_rdata, 0);
      chk("rstmid_d_gnt", d_gnt, 0);
      chk("rstmid_mem_en", mem_en, 0);
      @(posedge clk); #1;
      rst = 1'b0; i_req = 1'b0; d_read = 1'b0;
      @(negedge clk); #1;
      chk("rstrel_d_valid", d_valid, 0);
      chk("rstrel_i_valid", i_valid, 0);
      drive(0, 0, 1, 0, 32'h2C, 0);
      drive(0, 0, 0, 0, 0, 0);
      chk("rstrel_ld_valid", d_valid, 1);
      chk("rstrel_ld_data", d_rdata, 12);

      // Held fetch versus six back-to-back loads
      for (int k = 1; k <= 6; k++) begin
         drive(1, 32'h4, 1, 0, 32'h8, 0);
         chk($sformatf("guard_d_gnt%0d", k), d_gnt, (GUARD && k == 5) ? 0 : 1);
         chk($sformatf("guard_i_gnt%0d", k), i_gnt, (GUARD && k == 5) ? 1 : 0);
      end
      drive(1, 32'h4, 0, 0, 0, 0);
      chk("guard_after_drop", i_gnt, 1);
      drive(0, 0, 0, 0, 0, 0);

      // Randomized traffic, with occasional illegal read+write and reset pulses
      for (int n = 0; n < 3000; n++) begin
         int r;
         @(posedge clk); #1;
         r       = int'($urandom_range(0, 7));
         rst     = ($urandom_range(0, 199) == 0);
         i_req   = ($urandom_range(0, 3) != 0);
         i_addr  = $urandom;
         d_read  = (r == 1 || r == 2 || r == 3 || r == 7);
         d_write = (r == 4 || r == 5 || r == 7);
         d_addr  = $urandom;
         d_wdata = $urandom;
      end
      @(posedge clk); #1;
      rst = 1'b0; i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported synchronous RAM between the pipelined RV32 CPU's instruction-fetch port and its load/store port, so that the core can run from a unified memory image. Each cycle it grants at most one requester and drives the RAM. It returns read data one cycle later, tagged to the granted port, and raises per-port stalls that the CPU's hazard unit uses to freeze the fetch or memory stage.

## Interface
Parameters:
- ADDR_W, 32, CPU byte-address width
- DATA_W, 32, data word width
- MEM_AW, 6, RAM word-address width (64 words)
- STARVE_MAX, 4, consecutive fetch-blocked data grants before fetch is forced; used only with guard enabled

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, held until i_gnt
- i_addr  in  ADDR_W  fetch byte address
- i_gnt  out  1  fetch accepted this cycle (combinational)
- i_valid  out  1  fetch data valid (registered)
- i_rdata  out  DATA_W  fetch data
- i_stall  out  1  i_req && !i_gnt
- d_read  in  1  load request
- d_write  in  1  store request
- d_addr  in  ADDR_W  load/store byte address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data access accepted this cycle (combinational)
- d_valid  out  1  load data valid (registered); never pulses for stores
- d_rdata  out  DATA_W  load data
- d_stall  out  1  (d_read||d_write) && !d_gnt
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  MEM_AW  RAM word address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en && !mem_we

## Operation
- Word address = byte_addr[MEM_AW+1:2]. Bits [1:0] are ignored, and higher bits are dropped, so out-of-range addresses wrap modulo 2^MEM_AW words.
- Default priority is data over fetch, because the MEM-stage instruction is older.
- Grant, same cycle, combinational:
  - If a data request is pending and the guard is not forcing fetch: d_gnt=1, and the RAM is driven from d_addr/d_wdata with mem_we=d_write.
  - Else if i_req: i_gnt=1, the RAM is driven from i_addr, mem_we=0.
  - Else: mem_en=0.
- d_read and d_write both high is illegal. Write takes precedence and no d_valid is returned.
- Response tracking uses a registered owner: NONE, IFETCH or DLOAD. Owner is set on every rising edge from the grant of that cycle; a store sets NONE.
  - Owner=IFETCH: i_valid=1 and i_rdata=mem_rdata in the next cycle.
  - Owner=DLOAD: d_valid=1 and d_rdata=mem_rdata in the next cycle.
- Accesses are fully pipelined, one new grant every cycle. Back-to-back grants of either kind need no idle cycle.
- i_rdata/d_rdata hold their last captured value when their valid is low.

## Timing
- Reset values: i_valid=0, d_valid=0, i_rdata=0, d_rdata=0, owner=NONE, starvation count=0.
- While rst is high, i_gnt, d_gnt, mem_en and mem_we are forced to 0.
- Read latency: grant in cycle N, valid and data in cycle N+1.
- Store: RAM written at the end of the granted cycle. A load of the same address granted in N+1 returns the new data.
- Simultaneous i_req and d_req: data wins, i_stall=1, and fetch is retried automatically because the requester keeps i_req asserted.
- Reset asserted mid-access: the in-flight response is discarded and no valid pulses after reset is released.
- A request dropped before grant is legal and has no effect.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A saturating counter increments on each data grant made while i_req is pending, and clears on any fetch grant.
  - When the count reaches STARVE_MAX, the next cycle with i_req high grants fetch even if data is pending. d_stall=1 in that cycle and the counter clears.
- ARB_STARVE_GUARD_EN undefined: strict data priority, no counter logic.

## Test plan
- Fetch only: i_req with i_addr=0x0,0x4,0x8 on consecutive cycles, RAM preloaded with 0x00000213, 0x00022283, 0x00420213 -> i_gnt=1 each cycle; i_valid on the next three cycles with those words in order.
- Contention: i_req and d_read at 0x0 in the same cycle, RAM[0]=5 -> d_gnt=1, i_stall=1; next cycle d_valid=1, d_rdata=5, i_gnt=1; fetch data follows one cycle later.
- Store then load: d_write d_addr=0x2C d_wdata=12, then d_read 0x2C -> no d_valid for the store; d_valid=1, d_rdata=12 on the cycle after the load grant.
- Wrap and alignment: d_read at 0x103 with MEM_AW=6 -> mem_addr=0, data of word 0 returned.
- Reset mid-load: assert rst the cycle after a d_read grant -> d_valid stays 0, all outputs at reset values, and the next load after release works normally.
- Guard, with ARB_STARVE_GUARD_EN and STARVE_MAX=4: i_req held while d_read is held for 6 cycles -> data granted in 4 cycles, fetch granted in the 5th, data granted in the 6th. Without the macro, fetch is granted only after d_read drops.
